// File: rtl/my_type_arbiter_pkg.sv
// Shared types and helpers for the my_type_t channel arbiter.
//
// Contents:
//   my_mode_e   - mode field of a channel word
//   my_type_t   - channel word (mode + subtype)
//   arb_state_e - arbiter FSM state type, with ARB_IDLE / ARB_XFER constants
//   rr_pick     - round-robin winner search over up to MaxReq requesters
package my_type_arbiter_pkg;

  // Widest requester vector that rr_pick can scan.
  localparam int unsigned MaxReq = 16;

  typedef enum logic [1:0] {
    ModeCtrl = 2'd0,
    ModeData = 2'd1,
    ModeCfg  = 2'd2,
    ModeDbg  = 2'd3
  } my_mode_e;

  typedef struct packed {
    my_mode_e   mode;
    logic [5:0] subtype;
  } my_type_t;

  // Encoded as plain constants so the state vector stays a simple logic register.
  typedef logic [0:0] arb_state_e;
  localparam arb_state_e ARB_IDLE = 1'b0;
  localparam arb_state_e ARB_XFER = 1'b1;

  // Returns the first set bit of req scanning upward from last+1 and wrapping at nb_req.
  // When nothing is requesting the result is last; callers qualify with |req.
  function automatic logic [3:0] rr_pick(input logic [MaxReq-1:0] req,
                                         input logic [3:0]        last,
                                         input int unsigned       nb_req);
    logic [4:0] idx;
    rr_pick = last;
    // Walk from the farthest candidate down so the nearest one is written last and wins.
    for (int unsigned k = MaxReq; k >= 1; k--) begin
      if (k <= nb_req) begin
        idx = 5'(last) + 5'(k);
        if (32'(idx) >= nb_req) begin
          idx = idx - 5'(nb_req);
        end
        if (req[idx[3:0]]) begin
          rr_pick = idx[3:0];
        end
      end
    end
  endfunction

endpackage

// File: rtl/my_type_arbiter_if.sv
// Handshake bundle between NB_REQ producers, the arbiter and the single consumer.
//
// Signals:
//   req_valid/req_data/req_last  producer words, one lane per requester
//   req_ready                    per-lane accept (valid && ready transfers a word)
//   out_valid/out_data/out_last  registered output word to the consumer
//   out_src                      requester index that produced out_data
//   out_ready                    consumer back-pressure
// Modports:
//   master - producers and consumer (drives requests and out_ready)
//   slave  - the arbiter
interface my_type_arbiter_if
  import my_type_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ = 4
);

  localparam int unsigned SRC_W = $clog2(NB_REQ);

  logic     [NB_REQ-1:0] req_valid;
  my_type_t [NB_REQ-1:0] req_data;
  logic     [NB_REQ-1:0] req_last;
  logic     [NB_REQ-1:0] req_ready;

  logic                  out_valid;
  my_type_t              out_data;
  logic                  out_last;
  logic     [SRC_W-1:0]  out_src;
  logic                  out_ready;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src
  );

endinterface

// File: rtl/my_type_arb_rr_pick.sv
// Combinational round-robin picker.
//
// Ports:
//   req_i   [NB_REQ]  request vector
//   last_i  [SRC_W]   index granted most recently; search starts just above it
//   pick_o  [SRC_W]   winning index (meaningful only when |req_i)
module my_type_arb_rr_pick
  import my_type_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ = 4,
  localparam int unsigned SRC_W = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]  last_i,
  output logic [SRC_W-1:0]  pick_o
);

  logic [MaxReq-1:0] req_ext;

  assign req_ext = MaxReq'(req_i);
  assign pick_o  = SRC_W'(rr_pick(req_ext, 4'(last_i), NB_REQ));

endmodule

// File: rtl/my_type_arbiter.sv
// Round-robin arbiter and burst scheduler sharing one my_type_t channel between
// NB_REQ requesters. One requester is granted per burst; its words pass through a
// registered output stage. A burst ends on req_last or after BURST_MAX beats, after
// which one idle cycle is spent re-arbitrating.
//
// Ports:
//   clk               clock
//   rst               asynchronous active-high reset
//   bus_io            my_type_arbiter_if.slave (requester lanes + output channel)
//   busy_o            FSM not idle or an output word is still pending
//   stat_clr_i        clear all grant counters            (MY_TYPE_ARB_STATS_EN only)
//   stat_grant_cnt_o  saturating grants per requester     (MY_TYPE_ARB_STATS_EN only)
//
// Configuration:
//   MY_TYPE_ARB_STATS_EN - when defined, adds the CNT_W parameter, the stat ports and
//                          the per-requester grant counters. Otherwise they are absent.
module my_type_arbiter
  import my_type_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ    = 4,
  parameter int unsigned BURST_MAX = 8
`ifdef MY_TYPE_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  my_type_arbiter_if.slave            bus_io,
  output logic                        busy_o
`ifdef MY_TYPE_ARB_STATS_EN
  ,
  input  logic                        stat_clr_i,
  output logic [NB_REQ-1:0][CNT_W-1:0] stat_grant_cnt_o
`endif
);

  localparam int unsigned SRC_W  = $clog2(NB_REQ);
  localparam int unsigned BEAT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  arb_state_e        state_q, state_d;
  logic [SRC_W-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]  last_grant_q, last_grant_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic              out_valid_q, out_valid_d;
  my_type_t          out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;

  logic [NB_REQ-1:0] req_ready;
  logic [SRC_W-1:0]  pick;
  logic              arb_start;
  logic              accept;
  logic              burst_end;

  my_type_arb_rr_pick #(
    .NB_REQ (NB_REQ)
  ) u_rr_pick (
    .req_i  (bus_io.req_valid),
    .last_i (last_grant_q),
    .pick_o (pick)
  );

  // Handshake decode. Only the granted lane can be ready, and only when the output
  // register is empty or draining this cycle.
  always_comb begin
    req_ready = '0;
    if (state_q == ARB_XFER) begin
      req_ready[grant_q] = !out_valid_q || bus_io.out_ready;
    end
    arb_start = (state_q == ARB_IDLE) && (|bus_io.req_valid);
    accept    = (state_q == ARB_XFER) && bus_io.req_valid[grant_q] && req_ready[grant_q];
    // Forced cut on the BURST_MAX-th beat; it does not touch out_last.
    burst_end = accept &&
                (bus_io.req_last[grant_q] || (beat_cnt_q == BEAT_W'(BURST_MAX - 1)));
  end

  // FSM next state.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_start) begin
          state_d = ARB_XFER;
          grant_d = pick;
        end
      end
      ARB_XFER: begin
        if (burst_end) begin
          state_d      = ARB_IDLE;
          last_grant_d = grant_q;
          beat_cnt_d   = '0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Output register: load on accept, otherwise empty out once the consumer takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus_io.req_data[grant_q];
      out_last_d  = bus_io.req_last[grant_q];
      out_src_d   = grant_q;
    end else if (bus_io.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      // Starting from the top index makes requester 0 the first winner.
      last_grant_q <= SRC_W'(NB_REQ - 1);
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_src_q    <= out_src_d;
    end
  end

  assign bus_io.req_ready = req_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_last  = out_last_q;
  assign bus_io.out_src   = out_src_q;
  assign busy_o           = (state_q != ARB_IDLE) || out_valid_q;

`ifdef MY_TYPE_ARB_STATS_EN
  logic [NB_REQ-1:0][CNT_W-1:0] stat_cnt_q, stat_cnt_d;

  // Counts IDLE->XFER grants per winner; saturates, and a clear beats a same-cycle grant.
  always_comb begin
    stat_cnt_d = stat_cnt_q;
    if (stat_clr_i) begin
      stat_cnt_d = '0;
    end else if (arb_start && (stat_cnt_q[pick] != {CNT_W{1'b1}})) begin
      stat_cnt_d[pick] = stat_cnt_q[pick] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt_q <= '0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_grant_cnt_o = stat_cnt_q;
`endif

endmodule

// File: tb/tb_my_type_arbiter.sv
// Scoreboard bench for my_type_arbiter: directed packets are queued per requester,
// the expected output words are queued in hand-computed grant order, and a monitor
// pops and compares every word the consumer takes.
module tb_my_type_arbiter;
  import my_type_arbiter_pkg::*;

  localparam int unsigned NbReq    = 4;
  localparam int unsigned BurstMax = 8;

  typedef struct packed {
    my_type_t data;
    logic     last;
  } rq_t;

  typedef struct packed {
    logic [1:0] src;
    my_type_t   data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   cyc = 0;
  int   checks;
  int   errors;
  int   c0;

  rq_t  req_q [NbReq][$];
  exp_t exp_q[$];
  int   xfer_t[$];
  int   exp_times[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  my_type_arbiter_if #(.NB_REQ(NbReq)) bus ();

`ifdef MY_TYPE_ARB_STATS_EN
  localparam int unsigned CntW = 2;
  logic                        stat_clr;
  logic [NbReq-1:0][CntW-1:0]  stat_cnt;
`endif

  my_type_arbiter #(
    .NB_REQ    (NbReq),
    .BURST_MAX (BurstMax)
`ifdef MY_TYPE_ARB_STATS_EN
    ,
    .CNT_W     (CntW)
`endif
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus_io           (bus),
    .busy_o           (busy)
`ifdef MY_TYPE_ARB_STATS_EN
    ,
    .stat_clr_i       (stat_clr),
    .stat_grant_cnt_o (stat_cnt)
`endif
  );

  function automatic my_type_t mk(input int src, input int seq);
    logic [7:0] raw;
    raw = {src[1:0], seq[5:0]};
    return my_type_t'(raw);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic add_req(input int src, input int seq, input logic last);
    rq_t r;
    r.data = mk(src, seq);
    r.last = last;
    req_q[src].push_back(r);
  endtask

  task automatic add_exp(input int src, input int seq, input logic last);
    exp_t e;
    e.src  = src[1:0];
    e.data = mk(src, seq);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic flush();
    for (int i = 0; i < NbReq; i++) req_q[i].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    flush();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    xfer_t.delete();
    exp_times.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  task automatic check_times(input string name);
    chk({name, "_count"}, 32'(xfer_t.size()), 32'(exp_times.size()));
    for (int i = 0; i < exp_times.size(); i++) begin
      if (i < xfer_t.size()) begin
        chk($sformatf("%s_cyc%0d", name, i), 32'(xfer_t[i]), 32'(exp_times[i]));
      end
    end
  endtask

  // Requester driver: drop words accepted at the last edge, then present the next ones.
  initial begin
    logic [NbReq-1:0] acc;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      for (int i = 0; i < NbReq; i++) begin
        if (acc[i] && !rst && req_q[i].size() != 0) void'(req_q[i].pop_front());
      end
      #1;
      for (int i = 0; i < NbReq; i++) begin
        if (req_q[i].size() != 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i]  = req_q[i][0].data;
          bus.req_last[i]  = req_q[i][0].last;
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_data[i]  = '0;
          bus.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: a word is consumed at the next edge whenever valid && ready holds here.
  initial begin
    exp_t got;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got.src  = bus.out_src;
        got.data = bus.out_data;
        got.last = bus.out_last;
        xfer_t.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_word: got src=%0d data=%h last=%b, expected no word",
                   got.src, got.data, got.last);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL out_word: got src=%0d data=%h last=%b, expected src=%0d data=%h last=%b",
                     got.src, got.data, got.last, e.src, e.data, e.last);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
`ifdef MY_TYPE_ARB_STATS_EN
    stat_clr      = 1'b0;
`endif

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'({bus.out_data}), 32'(0));
    chk("rst_out_last", 32'(bus.out_last), 32'(0));
    chk("rst_out_src", 32'(bus.out_src), 32'(0));
    chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Req0 alone, 3 words: outputs at +2,+3,+4.
    @(negedge clk);
    c0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      add_req(0, k + 1, k == 2);
      add_exp(0, k + 1, k == 2);
      exp_times.push_back(c0 + 2 + k);
    end
    wait_drain("t1", 40);
    check_times("t1_time");
    repeat (2) @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'(0));

    // All four valid with 1-word packets: order 0,1,2,3,0 with a bubble between grants.
    do_reset();
    @(negedge clk);
    c0 = cyc + 1;
    add_req(0, 16, 1'b1);
    add_req(0, 17, 1'b1);
    add_req(1, 32, 1'b1);
    add_req(2, 48, 1'b1);
    add_req(3, 56, 1'b1);
    add_exp(0, 16, 1'b1);
    add_exp(1, 32, 1'b1);
    add_exp(2, 48, 1'b1);
    add_exp(3, 56, 1'b1);
    add_exp(0, 17, 1'b1);
    for (int k = 0; k < 5; k++) exp_times.push_back(c0 + 2 + 2 * k);
    wait_drain("t2", 60);
    check_times("t2_time");

    // Req2, 10 words without last: 8 beats, 1 bubble, 2 beats, out_last low throughout.
    do_reset();
    @(negedge clk);
    c0 = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      add_req(2, k, 1'b0);
      add_exp(2, k, 1'b0);
    end
    for (int k = 0; k < 8; k++) exp_times.push_back(c0 + 2 + k);
    exp_times.push_back(c0 + 11);
    exp_times.push_back(c0 + 12);
    wait_drain("t3", 60);
    check_times("t3_time");

    // Consumer stall of 5 cycles mid-burst on req1's 6-word packet.
    do_reset();
    @(negedge clk);
    c0 = cyc + 1;
    for (int k = 0; k < 6; k++) begin
      add_req(1, k, k == 5);
      add_exp(1, k, k == 5);
    end
    repeat (4) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t4_valid%0d", k), 32'(bus.out_valid), 32'(1));
      chk($sformatf("t4_data%0d", k), 32'({bus.out_data}), 32'({mk(1, 1)}));
      chk($sformatf("t4_ready%0d", k), 32'(bus.req_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain("t4", 40);

    // Reset during beat 4 of 6, then req0 must beat req3.
    do_reset();
    @(negedge clk);
    c0 = cyc + 1;
    for (int k = 0; k < 6; k++) begin
      add_req(1, 8 + k, k == 5);
      if (k < 3) add_exp(1, 8 + k, k == 5);
    end
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 32'(bus.out_valid), 32'(0));
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_req_ready", 32'(bus.req_ready), 32'(0));
    chk("t5_pre_words", 32'(exp_q.size()), 32'(0));
    flush();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    xfer_t.delete();
    exp_times.delete();
    @(negedge clk);
    c0 = cyc + 1;
    add_req(3, 58, 1'b1);
    add_req(0, 5, 1'b1);
    add_exp(0, 5, 1'b1);
    add_exp(3, 58, 1'b1);
    exp_times.push_back(c0 + 2);
    exp_times.push_back(c0 + 4);
    wait_drain("t5", 40);
    check_times("t5_time");

`ifdef MY_TYPE_ARB_STATS_EN
    // Grant counters: 3 grants, saturation at 3, clear beats a same-cycle grant.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      add_req(1, 40 + k, 1'b1);
      add_exp(1, 40 + k, 1'b1);
    end
    wait_drain("t6a", 40);
    repeat (2) @(negedge clk);
    chk("t6_cnt1_3", 32'(stat_cnt[1]), 32'(3));
    chk("t6_cnt0_0", 32'(stat_cnt[0]), 32'(0));
    @(negedge clk);
    add_req(1, 50, 1'b1);
    add_exp(1, 50, 1'b1);
    wait_drain("t6b", 40);
    repeat (2) @(negedge clk);
    chk("t6_cnt1_sat", 32'(stat_cnt[1]), 32'(3));
    @(negedge clk);
    add_req(1, 51, 1'b1);
    add_exp(1, 51, 1'b1);
    @(posedge clk);
    #1;
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    wait_drain("t6c", 40);
    repeat (2) @(negedge clk);
    chk("t6_cnt1_clr", 32'(stat_cnt[1]), 32'(0));
`endif

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
